// File: rtl/mspu_dwc_pkg.sv
// Shared types and constants for the 32->512 egress width converter.
// Beat geometry is fixed here and is not overridable per instance.
package mspu_dwc_pkg;

    localparam int BEAT_WORDS = 16;
    localparam int WORD_W     = 32;
    localparam int BEAT_W     = BEAT_WORDS * WORD_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        GAP,
        HOLD,
        DRAIN
    } state_e;

    function automatic word_t bswap32(word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/datawidthconv_32_to_512_if.sv
// Data RAM read port plus wide stream TX port of the 32->512 converter.
// master = converter side, slave = RAM/sink side.
interface datawidthconv_32_to_512_if;
    import mspu_dwc_pkg::*;

    logic [31:0] data_addr;
    logic        data_re;
    word_t       data_dout;
    beat_t       src_data;
    logic        src_valid;
    logic        src_sop;
    logic        src_eop;
    logic        src_ready;

    modport master (
        output data_addr, data_re,
        input  data_dout,
        output src_data, src_valid, src_sop, src_eop,
        input  src_ready
    );

    modport slave (
        input  data_addr, data_re,
        output data_dout,
        input  src_data, src_valid, src_sop, src_eop,
        output src_ready
    );

endinterface

// File: rtl/dwc_beat_packer.sv
// 16x32 shift-in beat assembler; first captured word lands in bits [31:0].
// DATAWIDTHCONV_32_TO_512_BSWAP_EN: byte-reverse each word on capture.
module dwc_beat_packer
    import mspu_dwc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr,
    input  logic  cap,
    input  word_t din,
    input  logic  pop,
    output beat_t beat,
    output logic  full
);

    beat_t      beat_q, beat_d;
    logic [3:0] cnt_q, cnt_d;
    logic       full_q, full_d;
    word_t      w;

    always_comb begin
`ifdef DATAWIDTHCONV_32_TO_512_BSWAP_EN
        w = bswap32(din);
`else
        w = din;
`endif
        beat_d = beat_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (pop) full_d = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (cap) begin
            beat_d = {w, beat_q[BEAT_W-1:WORD_W]};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(BEAT_WORDS - 1)) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            beat_q <= beat_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign beat = beat_q;
    assign full = full_q;

endmodule

// File: rtl/datawidthconv_32_to_512.sv
// Reads WORDS 32-bit words from data RAM and emits them as 512-bit beats.
// Byte swap on capture is enabled by DATAWIDTHCONV_32_TO_512_BSWAP_EN.
module datawidthconv_32_to_512
    import mspu_dwc_pkg::*;
#(
    parameter int WORDS = 512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        kick,
    input  logic [31:0] base_addr,
    output logic        busy,
    output logic        done,
    datawidthconv_32_to_512_if.master bus
);

    localparam int NB = WORDS / BEAT_WORDS;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST = BW'(NB - 1);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        re_q, re_d;
    logic        cap_q, cap_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic [BW-1:0] rd_beat_q, rd_beat_d;
    logic [BW-1:0] out_cnt_q, out_cnt_d;
    logic        valid_q, valid_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    beat_t       data_q, data_d;
    beat_t       pk_beat;
    logic        pk_full;
    logic        pk_clr;
    logic        xfer;
    logic        hs;

    dwc_beat_packer u_packer (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (pk_clr),
        .cap   (cap_q),
        .din   (bus.data_dout),
        .pop   (xfer),
        .beat  (pk_beat),
        .full  (pk_full)
    );

    always_comb begin
        xfer      = pk_full && (!valid_q || bus.src_ready);
        hs        = valid_q && bus.src_ready;
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        re_d      = re_q;
        cap_d     = re_q;
        addr_d    = addr_q;
        rd_cnt_d  = rd_cnt_q;
        rd_beat_d = rd_beat_q;
        out_cnt_d = out_cnt_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        data_d    = data_q;
        pk_clr    = 1'b0;

        if (xfer) begin
            valid_d   = 1'b1;
            data_d    = pk_beat;
            sop_d     = (out_cnt_q == '0);
            eop_d     = (out_cnt_q == LAST);
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                // busy_q still set here means this is the done cycle
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (kick) begin
                    state_d   = READ;
                    busy_d    = 1'b1;
                    re_d      = 1'b1;
                    addr_d    = base_addr & 32'hFFFF_FFFC;
                    rd_cnt_d  = '0;
                    rd_beat_d = '0;
                    out_cnt_d = '0;
                    pk_clr    = 1'b1;
                end
            end
            READ: begin
                addr_d   = addr_q + 32'd4;
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == 4'(BEAT_WORDS - 1)) begin
                    re_d    = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // empty output reg guarantees the packer drains next cycle
                if (rd_beat_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    rd_beat_d = rd_beat_q + 1'b1;
                    if (!valid_q) begin
                        state_d = READ;
                        re_d    = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = READ;
                    re_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (hs && eop_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            re_q      <= 1'b0;
            cap_q     <= 1'b0;
            addr_q    <= '0;
            rd_cnt_q  <= '0;
            rd_beat_q <= '0;
            out_cnt_q <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            re_q      <= re_d;
            cap_q     <= cap_d;
            addr_q    <= addr_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_beat_q <= rd_beat_d;
            out_cnt_q <= out_cnt_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            data_q    <= data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.data_re   = re_q;
    assign bus.data_addr = addr_q;
    assign bus.src_valid = valid_q;
    assign bus.src_sop   = sop_q;
    assign bus.src_eop   = eop_q;
    assign bus.src_data  = data_q;

endmodule
